merge_n: RTL and testbench
==========================

# merge_n

Parametrised N-way merge with hold-window tracking. Each cycle it forwards one of N held input channels to a single output. The channel is chosen by one-cycle `go` event pulses, and that choice is remembered until the next event. The block sits wherever several mutually-exclusive producers drive one consumer port. It adds three things to the two-way merge:

- an optional expiry window
- deterministic multi-event arbitration
- a sticky protocol-error flag

## Interface
Parameters:
- `N`, 2, number of input channels; must be ≥ 2, otherwise elaboration fails.
- `WIDTH`, 32, data width per channel.
- `HOLD`, 0, number of cycles `out_valid` stays high after an event, counting the event cycle. A value of 0 means the selection never expires.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserted when 0, released synchronously to `clk`.
- `go`  in  N  per-channel event pulses; bit i selects channel i.
- `in`  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]. The producer must hold its data for its whole window.
- `out`  out  WIDTH  selected channel data.
- `sel`  out  IDX_W  index of the selected channel, where IDX_W = max(1, $clog2(N)).
- `out_valid`  out  1  high while a selection is live.
- `conflict`  out  1  sticky flag: set when more than one `go` bit was high in the same cycle.

## Operation
- **State:** `sel_q` (IDX_W bits), `active_q` (1 bit), `cnt_q` (CW bits, CW = max(1, $clog2(HOLD+1))), `conflict_q` (1 bit).
- **Reset values:** all state is 0. Channel 0 is selected and nothing is live.
- **Grant:** `g` is the lowest index whose `go` bit is high. `any = |go`. `multi` is high when two or more `go` bits are high.
- **Selection index:** `idx = any ? g : sel_q`.
  - `out = in[idx]`, `sel = idx`, `out_valid = any | active_q`.
  - When `out_valid` is 0, `out` still forwards `in[sel_q]`. The output is deterministic and never X.
- **Next state on an event (`any`):**
  - `sel_q <= g`.
  - `cnt_q <= HOLD-1`. When HOLD=0, `cnt_q` is unused and held at 0.
  - `active_q <= (HOLD != 1)`.
- **Next state with no event:**
  - If `active_q` and HOLD≠0: `cnt_q <= cnt_q-1`, and `active_q <= 0` when `cnt_q == 1`.
  - Otherwise all state holds.
- **Retrigger:** a `go` pulse inside a live window, on the same or a different channel, restarts the window from the full HOLD. This is legal and does not set `conflict`.
- **Multiple events:** when `multi` is high, the lowest index wins and `conflict_q <= 1`. Only reset clears `conflict_q`.
- **Reset mid-window:** asserting `reset` clears all state immediately, without waiting for a clock edge.

## Timing
- **Without the output register:**
  - Latency from `go` to `out`/`sel`/`out_valid` is 0 cycles (combinational).
  - The new selection is remembered from the next edge onward.
- **Window length:** for HOLD=H≥1 and an event at cycle t with no later events, `out_valid` is high in cycles t…t+H-1 and low at t+H.
- **`conflict` timing:** rises on the edge after the offending cycle.
- **Outputs during reset:**
  - Combinational build: `out = in[0]`, `sel = 0`, `out_valid = 0`, `conflict = 0`.
  - Registered build (see Configuration): `out = 0`, `sel = 0`, `out_valid = 0`, `conflict = 0`.

## Configuration
- **Macro:** `MERGE_N_OUT_REG_EN`.
- **Defined:** `out`, `sel` and `out_valid` are registered from their combinational values.
  - Latency is 1 cycle, and every output window shifts one cycle later.
  - All three registers reset to 0.
  - `conflict` timing is unchanged.
- **Undefined:** combinational outputs with 0-cycle latency, as described in Operation.

## Structure
- **Package `merge_pkg`:**
  - function `idx_w(n)`, returning max(1, $clog2(n));
  - function `cnt_w(hold)`, returning max(1, $clog2(hold+1));
  - the flattened-bus slice convention, documented as a constant comment.
- **Sub-module `prio_enc #(N)`:**
  - inputs `req[N]`;
  - outputs `any`, `idx[IDX_W]`, `multi`;
  - purely combinational, lowest index first.
- **Top module:** `merge_n` contains the state registers, the window counter, the output mux and the optional output register stage.

## Test plan
1. **Reset:** with N=4, HOLD=0, hold `reset`=0 and set `in[0]`=0xA. Expect `out`=0xA, `sel`=0, `out_valid`=0, `conflict`=0.
2. **Select and keep:** with N=4, HOLD=0, pulse `go`=4'b0100 for 1 cycle with `in[2]`=0x55.
   - Expect `out`=0x55 and `sel`=2 in the pulse cycle.
   - Expect both held with `out_valid`=1 for 20 idle cycles.
3. **Window expiry:** with HOLD=3, pulse `go`=4'b0010 at cycle 10.
   - Expect `out_valid` high at cycles 10–12 and low at 13.
   - Expect `sel` to remain 1 afterwards.
4. **Multiple events:** pulse `go`=4'b1010 with `in[1]`=0x11 and `in[3]`=0x33.
   - Expect `out`=0x11 and `sel`=1, with `conflict` rising next cycle.
   - Expect `conflict` to stay 1 through later clean events until reset.
5. **Retrigger and mid-window reset:** with HOLD=4, pulse channel 0 at t and channel 3 at t+2.
   - Expect `out_valid` high from t through t+5.
   - Then pulse channel 1 and drop `reset` asynchronously at t+7 mid-cycle. Expect `out_valid`=0 and `sel`=0 immediately.
6. **Registered build:** with `MERGE_N_OUT_REG_EN` defined, repeat scenario 3. Expect `out_valid` high at cycles 11–13 and the `sel`/`out` change at 11.

Source files
------------

// File: rtl/merge_pkg.sv
// merge_n shared package: width helpers for the N-way merge.
// Flattened buses: channel i occupies bits [i*WIDTH +: WIDTH].
package merge_pkg;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int hold);
    return (hold > 1) ? $clog2(hold + 1) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with multi-hit detect.
// Purely combinational.
module prio_enc
  import merge_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic             multi
);

  always_comb begin
    any   = |req;
    multi = |(req & (req - N'(1)));
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/merge_n.sv
// N-way held merge with expiry window and sticky conflict flag.
// Optional output register stage: MERGE_N_OUT_REG_EN.
module merge_n
  import merge_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 32,
  parameter int HOLD  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             go,
  input  logic [N*WIDTH-1:0]       in,
  output logic [WIDTH-1:0]         out,
  output logic [idx_w(N)-1:0]      sel,
  output logic                     out_valid,
  output logic                     conflict
);

  localparam int IDX_W = idx_w(N);
  localparam int CW    = cnt_w(HOLD);
  localparam int HM1   = (HOLD == 0) ? 0 : HOLD - 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HM1);

  if (N < 2) begin : g_bad_n
    $error("merge_n: N must be >= 2");
  end

  logic [IDX_W-1:0] sel_q;
  logic             active_q;
  logic [CW-1:0]    cnt_q;
  logic             conflict_q;

  logic             any;
  logic             multi;
  logic [IDX_W-1:0] g;

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] mux_out;
  logic             mux_valid;

  prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .req   (go),
    .any   (any),
    .idx   (g),
    .multi (multi)
  );

  // Gate with reset so outputs are quiet while reset is held.
  always_comb begin
    idx       = any ? g : sel_q;
    mux_valid = reset & (any | active_q);
    if (!reset) idx = '0;
    mux_out = in[int'(idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= '0;
      active_q   <= 1'b0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (multi) conflict_q <= 1'b1;
      if (any) begin
        sel_q    <= g;
        cnt_q    <= CNT_INIT;
        active_q <= (HOLD != 1);
      end else if (active_q && HOLD != 0) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) active_q <= 1'b0;
      end
    end
  end

  assign conflict = conflict_q;

`ifdef MERGE_N_OUT_REG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= mux_out;
      sel       <= idx;
      out_valid <= mux_valid;
    end
  end
`else
  assign out       = mux_out;
  assign sel       = idx;
  assign out_valid = mux_valid;
`endif

endmodule

// File: tb/tb_merge_n.sv
// Directed bench for merge_n: three instances (HOLD 0/3/4), N=4.
// Expectations shift by one cycle when MERGE_N_OUT_REG_EN is set.
module tb_merge_n;

`ifdef MERGE_N_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  go;
  logic [31:0] din;

  logic [7:0] out0, out3, out4;
  logic [1:0] sel0, sel3, sel4;
  logic       val0, val3, val4;
  logic       con0, con3, con4;

  merge_n #(.N(4), .WIDTH(8), .HOLD(0)) u_h0 (
    .clk(clk), .reset(reset), .go(go), .in(din),
    .out(out0), .sel(sel0), .out_valid(val0), .conflict(con0)
  );
  merge_n #(.N(4), .WIDTH(8), .HOLD(3)) u_h3 (
    .clk(clk), .reset(reset), .go(go), .in(din),
    .out(out3), .sel(sel3), .out_valid(val3), .conflict(con3)
  );
  merge_n #(.N(4), .WIDTH(8), .HOLD(4)) u_h4 (
    .clk(clk), .reset(reset), .go(go), .in(din),
    .out(out4), .sel(sel4), .out_valid(val4), .conflict(con4)
  );

  always #5 clk = ~clk;

  int         dsel;
  logic [7:0] o_out;
  logic [1:0] o_sel;
  logic       o_val;
  logic       o_con;

  always_comb begin
    o_out = out0; o_sel = sel0; o_val = val0; o_con = con0;
    case (dsel)
      1: begin o_out = out3; o_sel = sel3; o_val = val3; o_con = con3; end
      2: begin o_out = out4; o_sel = sel4; o_val = val4; o_con = con4; end
      default: ;
    endcase
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] vg[32];
  logic       ev[32];
  logic [1:0] es[32];
  logic [7:0] eo[32];
  logic       ec[32];
  int         vlen;

  task automatic row(input int k, input logic [3:0] g, input logic v,
                     input logic [1:0] s, input logic [7:0] o,
                     input logic c);
    vg[k] = g; ev[k] = v; es[k] = s; eo[k] = o; ec[k] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    go    = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic run_vec(input string name);
    for (int k = 0; k < vlen + LAT; k++) begin
      go = (k < vlen) ? vg[k] : 4'b0;
      @(negedge clk);
      if (k >= LAT) begin
        chk($sformatf("%s valid c%0d", name, k - LAT), o_val, ev[k-LAT]);
        chk($sformatf("%s sel c%0d", name, k - LAT), o_sel, es[k-LAT]);
        chk($sformatf("%s out c%0d", name, k - LAT), o_out, eo[k-LAT]);
      end
      chk($sformatf("%s conflict c%0d", name, k), o_con,
          ec[(k < vlen) ? k : vlen - 1]);
      tick();
    end
    go = '0;
  endtask

  initial begin
    dsel  = 0;
    reset = 1'b0;
    go    = '0;
    din   = {8'h33, 8'h55, 8'h11, 8'h0A};

    // reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst out", o_out, (LAT != 0) ? 8'h00 : 8'h0A);
    chk("rst sel", o_sel, 2'd0);
    chk("rst valid", o_val, 1'b0);
    chk("rst conflict", o_con, 1'b0);
    chk("rst valid h3", val3, 1'b0);
    tick();

    // select and keep, HOLD=0
    dsel = 0;
    do_reset();
    vlen = 22;
    row(0, 4'b0000, 1'b0, 2'd0, 8'h0A, 1'b0);
    row(1, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0);
    for (int k = 2; k < 22; k++) row(k, 4'b0000, 1'b1, 2'd2, 8'h55, 1'b0);
    run_vec("keep");

    // window expiry, HOLD=3
    dsel = 1;
    do_reset();
    vlen = 16;
    for (int k = 0; k < 10; k++) row(k, 4'b0000, 1'b0, 2'd0, 8'h0A, 1'b0);
    row(10, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
    row(11, 4'b0000, 1'b1, 2'd1, 8'h11, 1'b0);
    row(12, 4'b0000, 1'b1, 2'd1, 8'h11, 1'b0);
    for (int k = 13; k < 16; k++) row(k, 4'b0000, 1'b0, 2'd1, 8'h11, 1'b0);
    run_vec("expire");

    // multiple events, sticky conflict
    dsel = 0;
    do_reset();
    vlen = 5;
    row(0, 4'b0000, 1'b0, 2'd0, 8'h0A, 1'b0);
    row(1, 4'b1010, 1'b1, 2'd1, 8'h11, 1'b0);
    row(2, 4'b0000, 1'b1, 2'd1, 8'h11, 1'b1);
    row(3, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b1);
    row(4, 4'b0000, 1'b1, 2'd2, 8'h55, 1'b1);
    run_vec("multi");
    do_reset();
    @(negedge clk);
    chk("multi conflict cleared", o_con, 1'b0);
    tick();

    // retrigger then asynchronous mid-window reset, HOLD=4
    dsel = 2;
    do_reset();
    vlen = 8;
    row(0, 4'b0000, 1'b0, 2'd0, 8'h0A, 1'b0);
    row(1, 4'b0001, 1'b1, 2'd0, 8'h0A, 1'b0);
    row(2, 4'b0000, 1'b1, 2'd0, 8'h0A, 1'b0);
    row(3, 4'b1000, 1'b1, 2'd3, 8'h33, 1'b0);
    row(4, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b0);
    row(5, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b0);
    row(6, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b0);
    row(7, 4'b0000, 1'b0, 2'd3, 8'h33, 1'b0);
    run_vec("retrig");
    go = 4'b0010;
    #2;
    reset = 1'b0;
    #1;
    chk("async rst valid", o_val, 1'b0);
    chk("async rst sel", o_sel, 2'd0);
    chk("async rst out", o_out, (LAT != 0) ? 8'h00 : 8'h0A);
    chk("async rst conflict", o_con, 1'b0);
    go = '0;
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
